// File: rtl/i2s_rx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_rx_framer_if
//  Brief    : Stereo-pair valid/ready bus between the I2S receive framer and
//             the parallel side of the RX path (RX FIFO writer).
//  Revision : 1.0 - initial release
// ============================================================================
interface i2s_rx_framer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] out_left;
    logic [WIDTH-1:0] out_right;
    logic             out_valid;
    logic             out_ready;

    // Framer side: produces pairs, observes consumer readiness.
    modport master (
        output out_left,
        output out_right,
        output out_valid,
        input  out_ready
    );

    // Consumer side: takes pairs, drives readiness.
    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/i2s_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_rx_framer
//  Brief    : Slave-mode I2S receive framer. Runs on the serial bit clock,
//             follows WS transitions, deserialises SD (MSB first, one-bit
//             WS delay) into left/right words and offers each complete
//             stereo pair on a valid/ready bus. Flags short channels and
//             pairs dropped under backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_framer #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en,
    input  wire logic        frame_32,
    input  wire logic        mute,
    input  wire logic        ws,
    input  wire logic        sd,
    i2s_rx_framer_if.master  out_if,
    output logic             overrun,
    output logic             frame_err
);

    localparam logic [5:0] c_w16 = 6'd16;
    localparam logic [5:0] c_w32 = 6'd32;

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_ws_d;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_left_hold;
    logic             r_left_bad;
    logic             r_f32;
    logic [WIDTH-1:0] r_out_left;
    logic [WIDTH-1:0] r_out_right;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_frame_err;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [5:0]       w_cnt_nxt;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] w_left_hold_nxt;
    logic             w_left_bad_nxt;
    logic             w_f32_nxt;
    logic [WIDTH-1:0] w_out_left_nxt;
    logic [WIDTH-1:0] w_out_right_nxt;
    logic             w_out_valid_nxt;
    logic             w_overrun_nxt;
    logic             w_frame_err_nxt;

    // Pair completion strobe and the right word that goes with it.
    logic             w_pair;
    logic [WIDTH-1:0] w_pair_right;

    // ------------------------------------------------------------------
    // Per-bit helpers
    // ------------------------------------------------------------------
    logic             w_fall;
    logic             w_rise;
    logic [5:0]       w_w;
    logic [5:0]       w_cnt_inc;
    logic [WIDTH-1:0] w_sreg_shift;
    logic             w_short;

    assign w_fall       = r_ws_d & ~ws;
    assign w_rise       = ~r_ws_d & ws;
    assign w_w          = r_f32 ? c_w32 : c_w16;
    // Bit counter includes the edge cycle and stops at W+1 so a long slot
    // never wraps back into the "short" range.
    assign w_cnt_inc    = (r_cnt > w_w) ? r_cnt : r_cnt + 6'd1;
    // Only bits 1..W enter the shift register; extra slot bits are dropped.
    assign w_sreg_shift = (r_cnt < w_w) ? {r_sreg[WIDTH-2:0], sd} : r_sreg;
    assign w_short      = (w_cnt_inc < w_w);

    // Channel-tracking FSM: next state, counters, capture and error strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sreg_nxt      = r_sreg;
        w_left_hold_nxt = r_left_hold;
        w_left_bad_nxt  = r_left_bad;
        w_f32_nxt       = r_f32;
        w_frame_err_nxt = 1'b0;
        w_pair          = 1'b0;
        w_pair_right    = '0;

        if (!en) begin
            // Disabled: drop any frame in progress and wait for a fresh
            // falling WS edge once re-enabled.
            w_state_nxt    = S_SYNC;
            w_cnt_nxt      = '0;
            w_sreg_nxt     = '0;
            w_left_bad_nxt = 1'b0;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_fall) begin
                        w_state_nxt    = S_LEFT;
                        w_cnt_nxt      = '0;
                        w_sreg_nxt     = '0;
                        w_left_bad_nxt = 1'b0;
                        w_f32_nxt      = frame_32;
                    end
                end

                S_LEFT: begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_sreg_nxt = w_sreg_shift;
                    if (w_rise) begin
                        if (w_short) begin
                            w_frame_err_nxt = 1'b1;
                            w_left_bad_nxt  = 1'b1;
                        end else begin
                            w_left_hold_nxt = mute ? '0 : w_sreg_shift;
                            w_left_bad_nxt  = 1'b0;
                        end
                        w_state_nxt = S_RIGHT;
                        w_cnt_nxt   = '0;
                        w_sreg_nxt  = '0;
                    end
                end

                S_RIGHT: begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_sreg_nxt = w_sreg_shift;
                    if (w_fall) begin
                        if (r_left_bad || w_short) begin
                            w_frame_err_nxt = 1'b1;
                        end else begin
                            w_pair       = 1'b1;
                            w_pair_right = mute ? '0 : w_sreg_shift;
                        end
                        w_state_nxt    = S_LEFT;
                        w_cnt_nxt      = '0;
                        w_sreg_nxt     = '0;
                        w_left_bad_nxt = 1'b0;
                        w_f32_nxt      = frame_32;
                    end
                end

                default: begin
                    w_state_nxt = S_SYNC;
                    w_cnt_nxt   = '0;
                    w_sreg_nxt  = '0;
                end
            endcase
        end
    end

    // Output handshake: load a completed pair, or drop it if the last one
    // is still pending; otherwise retire the pending pair when accepted.
    always_comb begin
        w_out_left_nxt  = r_out_left;
        w_out_right_nxt = r_out_right;
        w_out_valid_nxt = r_out_valid;
        w_overrun_nxt   = 1'b0;

        if (w_pair) begin
            if (r_out_valid && !out_if.out_ready) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_out_left_nxt  = r_left_hold;
                w_out_right_nxt = w_pair_right;
                w_out_valid_nxt = 1'b1;
            end
        end else if (r_out_valid && out_if.out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SYNC;
            r_ws_d      <= 1'b0;
            r_cnt       <= '0;
            r_sreg      <= '0;
            r_left_hold <= '0;
            r_left_bad  <= 1'b0;
            r_f32       <= 1'b0;
            r_out_left  <= '0;
            r_out_right <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ws_d      <= ws;
            r_cnt       <= w_cnt_nxt;
            r_sreg      <= w_sreg_nxt;
            r_left_hold <= w_left_hold_nxt;
            r_left_bad  <= w_left_bad_nxt;
            r_f32       <= w_f32_nxt;
            r_out_left  <= w_out_left_nxt;
            r_out_right <= w_out_right_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_overrun   <= w_overrun_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign out_if.out_left  = r_out_left;
    assign out_if.out_right = r_out_right;
    assign out_if.out_valid = r_out_valid;
    assign overrun          = r_overrun;
    assign frame_err        = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_rx_framer
//  Brief    : Directed self-checking bench for i2s_rx_framer: 16/32-bit
//             frames, backpressure/overrun, short and long slots, mute and
//             mid-frame reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_framer;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic frame_32;
    logic mute;
    logic ws;
    logic sd;
    logic overrun;
    logic frame_err;

    i2s_rx_framer_if #(.WIDTH(32)) u_if ();

    i2s_rx_framer #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .frame_32  (frame_32),
        .mute      (mute),
        .ws        (ws),
        .sd        (sd),
        .out_if    (u_if.master),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int ferr0;
    int ovr0;
    logic pend;
    logic cur_ws;

    // Tally single-cycle status pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            ferr_cnt <= ferr_cnt + int'(frame_err);
            ovr_cnt  <= ovr_cnt + int'(overrun);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit k (1-based) of a channel slot: data MSB first, then junk ones.
    function automatic logic bitval(input logic [31:0] data, input int nb, input int k);
        if (k <= nb) return data[nb-k];
        return 1'b1;
    endfunction

    task automatic clk_bit(input logic w, input logic d);
        ws = w;
        sd = d;
        @(posedge clk);
        #1;
    endtask

    // First cycle of a slot: WS changes, SD carries the previous LSB.
    task automatic open_chan(input logic w);
        cur_ws = w;
        clk_bit(w, pend);
    endtask

    // Remaining slot cycles; the last data bit is left pending for the edge.
    task automatic body(input logic [31:0] data, input int nb, input int slot);
        for (int k = 1; k < slot; k++) clk_bit(cur_ws, bitval(data, nb, k));
        pend = bitval(data, nb, slot);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; frame_32 = 1'b0; mute = 1'b0;
        ws = 1'b1; sd = 1'b0; u_if.out_ready = 1'b1; pend = 1'b0; cur_ws = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", u_if.out_valid, 0);
        check("rst_left",  u_if.out_left,  0);
        check("rst_right", u_if.out_right, 0);
        check("rst_ovr",   overrun,        0);
        check("rst_ferr",  frame_err,      0);
        rst = 1'b0;
        repeat (3) clk_bit(1'b1, 1'b0);

        // 16-bit frame
        open_chan(1'b0); body(32'hA5C3, 16, 16);
        open_chan(1'b1); check("t1_lerr", frame_err, 0);
        body(32'h1234, 16, 16);
        check("t1_latency", u_if.out_valid, 0);
        frame_32 = 1'b1;
        open_chan(1'b0);
        check("t1_valid", u_if.out_valid, 1);
        check("t1_left",  u_if.out_left,  32'h0000A5C3);
        check("t1_right", u_if.out_right, 32'h00001234);

        // 32-bit frame
        ferr0 = ferr_cnt;
        body(32'hDEADBEEF, 32, 32);
        check("t2_vclr", u_if.out_valid, 0);
        open_chan(1'b1); body(32'h01234567, 32, 32);
        frame_32 = 1'b0;
        open_chan(1'b0);
        check("t2_valid", u_if.out_valid, 1);
        check("t2_left",  u_if.out_left,  32'hDEADBEEF);
        check("t2_right", u_if.out_right, 32'h01234567);
        check("t2_ferr",  ferr_cnt - ferr0, 0);

        // Backpressure over two frames
        body(32'h1111, 16, 16);
        u_if.out_ready = 1'b0;
        open_chan(1'b1); body(32'h2222, 16, 16);
        open_chan(1'b0);
        check("t3_valid1", u_if.out_valid, 1);
        check("t3_left1",  u_if.out_left,  32'h1111);
        check("t3_ovr1",   overrun,        0);
        ovr0 = ovr_cnt;
        body(32'h3333, 16, 16);
        open_chan(1'b1); body(32'h4444, 16, 16);
        open_chan(1'b0);
        check("t3_ovr2",   overrun,        1);
        check("t3_valid2", u_if.out_valid, 1);
        check("t3_left2",  u_if.out_left,  32'h1111);
        check("t3_right2", u_if.out_right, 32'h2222);
        u_if.out_ready = 1'b1;

        // Short left channel (12 clocks)
        body(32'h5A5A, 16, 12);
        check("t3_vclr",   u_if.out_valid, 0);
        check("t3_hold",   u_if.out_left,  32'h1111);
        check("t3_ovrcnt", ovr_cnt - ovr0, 1);
        open_chan(1'b1); check("t4_ferr_rise", frame_err, 1);
        body(32'h6666, 16, 16);
        open_chan(1'b0);
        check("t4_ferr_fall", frame_err,      1);
        check("t4_novalid",   u_if.out_valid, 0);
        body(32'h0F0F, 16, 16);
        open_chan(1'b1); check("t4_next_ferr", frame_err, 0);
        body(32'hF0F0, 16, 16);
        open_chan(1'b0);
        check("t4_valid", u_if.out_valid, 1);
        check("t4_left",  u_if.out_left,  32'h0F0F);
        check("t4_right", u_if.out_right, 32'hF0F0);
        mute = 1'b1;

        // Muted frame
        body(32'hFFFF, 16, 16);
        open_chan(1'b1); body(32'hFFFF, 16, 16);
        open_chan(1'b0);
        check("t6_valid", u_if.out_valid, 1);
        check("t6_left",  u_if.out_left,  0);
        check("t6_right", u_if.out_right, 0);
        mute = 1'b0;

        // Long slot: 24 clocks per channel, 16-bit words
        ferr0 = ferr_cnt;
        body(32'hBEEF, 16, 24);
        open_chan(1'b1); body(32'hCAFE, 16, 24);
        open_chan(1'b0);
        check("t5_valid", u_if.out_valid, 1);
        check("t5_left",  u_if.out_left,  32'h0000BEEF);
        check("t5_right", u_if.out_right, 32'h0000CAFE);
        check("t5_ferr",  ferr_cnt - ferr0, 0);
        u_if.out_ready = 1'b0;

        // Reset in the middle of a left channel
        for (int k = 1; k < 8; k++) clk_bit(1'b0, bitval(32'h7777, 16, k));
        rst = 1'b1;
        #1;
        check("mr_valid", u_if.out_valid, 0);
        check("mr_left",  u_if.out_left,  0);
        check("mr_right", u_if.out_right, 0);
        check("mr_ferr",  frame_err,      0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (8) clk_bit(1'b0, 1'b1);
        pend = 1'b0;
        open_chan(1'b1); body(32'h9999, 16, 16);
        check("mr_nopair_r", u_if.out_valid, 0);
        open_chan(1'b0);
        check("mr_nopair_f", u_if.out_valid, 0);
        body(32'h1357, 16, 16);
        open_chan(1'b1); body(32'h2468, 16, 16);
        open_chan(1'b0);
        check("mr_valid2", u_if.out_valid, 1);
        check("mr_left2",  u_if.out_left,  32'h1357);
        check("mr_right2", u_if.out_right, 32'h2468);
        repeat (4) clk_bit(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
